router_fsm: RTL and testbench

- Control state machine for the 1x3 router input path.
- Decodes the destination address from the header byte and sequences the router register block through its load, FIFO-full, parity and error-check phases.
- Drives write enable towards the three output FIFOs and asserts `busy` back-pressure to the packet source.
- Sits between the source interface, the router register block and the FIFO/synchronizer block.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_fsm.sv | 128 ++++++++++++
 tb/tb_router_fsm.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared state encoding and port constants for the 1x3 router input path.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam int         NUM_PORTS    = 3;

    // Pick one per-port flag by destination address; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] vec, input logic [1:0] addr);
        case (addr)
            2'd0:    return vec[0];
            2'd1:    return vec[1];
            2'd2:    return vec[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router input-path control FSM: header decode, load/full/parity sequencing, FIFO write enable.
// Latency: Moore outputs follow the state register, one cycle after the transition edge.
// Backpressure: busy holds the source in every state except DECODE_ADDRESS and LOAD_DATA.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              wait_timeout
);

    localparam int              CNT_W      = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
    localparam bit              TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit;
    logic [NUM_PORTS-1:0] empty_vec, srst_vec;
    logic                hdr_ok, hdr_empty, sel_empty, sel_srst;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

    // Header path uses the live address; all later phases use the latched one.
    assign hdr_ok    = pkt_valid && (data_in != ADDR_W'(ADDR_INVALID));
    assign hdr_empty = port_sel(empty_vec, data_in[1:0]);
    assign sel_empty = port_sel(empty_vec, addr_q[1:0]);
    assign sel_srst  = port_sel(srst_vec, addr_q[1:0]);

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        if (state != DECODE_ADDRESS && sel_srst) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (hdr_ok)
                        state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_nxt = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_nxt = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_nxt = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_nxt = LOAD_PARITY;
                    else
                        state_nxt = LOAD_DATA;
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    // Empty beats an expiring timeout in the same cycle.
                    if (sel_empty) begin
                        state_nxt = LOAD_FIRST_DATA;
                    end else if (TIMEOUT_EN && wait_cnt == CNT_LAST) begin
                        state_nxt   = DECODE_ADDRESS;
                        timeout_hit = 1'b1;
                    end
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= DECODE_ADDRESS;
            addr_q       <= '0;
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_timeout <= timeout_hit;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_q <= data_in;
            // Counter only runs while staying in WAIT_TILL_EMPTY, so entry and exit both clear it.
            if (state == WAIT_TILL_EMPTY && state_nxt == WAIT_TILL_EMPTY)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: default instance plus a WAIT_LIMIT=4 instance sharing the same stimulus.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    logic m_detect_add, m_lfd_state, m_ld_state, m_laf_state, m_full_state;
    logic m_rst_int_reg, m_write_enb_reg, m_busy, m_wait_timeout;
    logic a_detect_add, a_lfd_state, a_ld_state, a_laf_state, a_full_state;
    logic a_rst_int_reg, a_write_enb_reg, a_busy, a_wait_timeout;
    logic [8:0] m_out, a_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    router_fsm #(.ADDR_W(2), .WAIT_LIMIT(255)) u_main (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(m_detect_add), .lfd_state(m_lfd_state), .ld_state(m_ld_state),
        .laf_state(m_laf_state), .full_state(m_full_state), .rst_int_reg(m_rst_int_reg),
        .write_enb_reg(m_write_enb_reg), .busy(m_busy), .wait_timeout(m_wait_timeout)
    );

    router_fsm #(.ADDR_W(2), .WAIT_LIMIT(4)) u_aux (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(a_detect_add), .lfd_state(a_lfd_state), .ld_state(a_ld_state),
        .laf_state(a_laf_state), .full_state(a_full_state), .rst_int_reg(a_rst_int_reg),
        .write_enb_reg(a_write_enb_reg), .busy(a_busy), .wait_timeout(a_wait_timeout)
    );

    assign m_out = {m_detect_add, m_lfd_state, m_ld_state, m_laf_state, m_full_state,
                    m_rst_int_reg, m_write_enb_reg, m_busy, m_wait_timeout};
    assign a_out = {a_detect_add, a_lfd_state, a_ld_state, a_laf_state, a_full_state,
                    a_rst_int_reg, a_write_enb_reg, a_busy, a_wait_timeout};

    typedef struct {
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] e;   // {empty_2, empty_1, empty_0}
        logic [2:0] sr;  // {soft_reset_2, soft_reset_1, soft_reset_0}
        logic       pd;
        logic       lpv;
        state_t     nxt;
    } vec_t;

    typedef struct {
        int         id;
        logic       chk_m;
        logic [8:0] em;
        logic       chk_a;
        logic [8:0] ea;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t cur;

    // Expected output bundle for a given state, in m_out/a_out bit order.
    function automatic logic [8:0] outs_of(input state_t s, input logic to);
        logic [8:0] o;
        o[8] = (s == DECODE_ADDRESS);
        o[7] = (s == LOAD_FIRST_DATA);
        o[6] = (s == LOAD_DATA);
        o[5] = (s == LOAD_AFTER_FULL);
        o[4] = (s == FIFO_FULL_STATE);
        o[3] = (s == CHECK_PARITY_ERROR);
        o[2] = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o[1] = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
        o[0] = to;
        return o;
    endfunction

    function automatic vec_t mkv(input logic pv, input logic [1:0] d, input logic ff,
                                 input logic [2:0] e, input logic [2:0] sr, input logic pd,
                                 input logic lpv, input state_t nxt);
        vec_t v;
        v.pv = pv; v.d = d; v.ff = ff; v.e = e; v.sr = sr; v.pd = pd; v.lpv = lpv; v.nxt = nxt;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d: outputs got %b expected %b", name, id, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        pkt_valid     = v.pv;
        data_in       = v.d;
        fifo_full     = v.ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.e;
        {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
        parity_done   = v.pd;
        low_pkt_valid = v.lpv;
    endtask

    task automatic step(input vec_t v, input int id, input logic cm, input logic [8:0] em,
                        input logic ca, input logic [8:0] ea);
        exp_t x;
        @(negedge clock);
        apply(v);
        x.id = id; x.chk_m = cm; x.em = em; x.chk_a = ca; x.ea = ea;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        apply(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Scoreboard drain: expectations pushed at a negedge are due just after the next rising edge.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.chk_m) check("main", cur.id, m_out, cur.em);
            if (cur.chk_a) check("aux", cur.id, a_out, cur.ea);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t w;

        // Group A: normal packet to port 1 (LFD ignores fifo_full).
        tbl.push_back(mkv(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
        tbl.push_back(mkv(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_PARITY));
        tbl.push_back(mkv(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR));
        tbl.push_back(mkv(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        tbl.push_back(mkv(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        // Group B: full stall on port 0, after-full branches.
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL));
        tbl.push_back(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, LOAD_PARITY));
        tbl.push_back(mkv(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR));
        tbl.push_back(mkv(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
        tbl.push_back(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL));
        tbl.push_back(mkv(0, 2'd0, 0, 3'b111, 3'b000, 1, 1, DECODE_ADDRESS));
        // Group C: soft reset selection on port 0.
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b010, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b110, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b001, 0, 0, LOAD_FIRST_DATA));
        tbl.push_back(mkv(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(1, 2'd0, 1, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS));
        // Group D: invalid address and idle header.
        tbl.push_back(mkv(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        tbl.push_back(mkv(1, 2'd3, 0, 3'b000, 3'b000, 0, 0, DECODE_ADDRESS));
        tbl.push_back(mkv(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        // Group E: port 2 busy for 10 cycles, other ports' flags must be ignored.
        tbl.push_back(mkv(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mkv(1, 2'd2, 0, 3'b011, 3'b011, 0, 0, WAIT_TILL_EMPTY));
        tbl.push_back(mkv(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
        tbl.push_back(mkv(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
        tbl.push_back(mkv(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, LOAD_PARITY));
        tbl.push_back(mkv(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR));
        tbl.push_back(mkv(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        tbl.push_back(mkv(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY));
        tbl.push_back(mkv(1, 2'd2, 0, 3'b011, 3'b100, 0, 0, DECODE_ADDRESS));

        // Reset value, asserted away from any clock edge.
        apply(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        resetn = 1'b0;
        #12;
        check("reset_main", 0, m_out, outs_of(DECODE_ADDRESS, 1'b0));
        check("reset_aux", 0, a_out, outs_of(DECODE_ADDRESS, 1'b0));
        @(negedge clock);
        resetn = 1'b1;

        // Asynchronous reset mid-packet.
        w = mkv(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA);
        step(w, 900, 1, outs_of(LOAD_FIRST_DATA, 0), 1, outs_of(LOAD_FIRST_DATA, 0));
        step(w, 901, 1, outs_of(LOAD_DATA, 0), 1, outs_of(LOAD_DATA, 0));
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_main", 902, m_out, outs_of(DECODE_ADDRESS, 1'b0));
        check("async_rst_aux", 902, a_out, outs_of(DECODE_ADDRESS, 1'b0));
        apply(mkv(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
        @(negedge clock);
        resetn = 1'b1;

        foreach (tbl[i])
            step(tbl[i], i, 1, outs_of(tbl[i].nxt, 1'b0), 0, '0);

        // Timeout with WAIT_LIMIT=4: header held, port 2 never drains; default instance keeps waiting.
        do_reset();
        w = mkv(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY);
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                step(w, 1000 + k, 1, outs_of(WAIT_TILL_EMPTY, 0), 1, outs_of(DECODE_ADDRESS, 1'b1));
            else
                step(w, 1000 + k, 1, outs_of(WAIT_TILL_EMPTY, 0), 1, outs_of(WAIT_TILL_EMPTY, 1'b0));
        end

        // Empty arriving on the timeout cycle wins.
        do_reset();
        for (int k = 0; k < 4; k++)
            step(w, 1100 + k, 1, outs_of(WAIT_TILL_EMPTY, 0), 1, outs_of(WAIT_TILL_EMPTY, 0));
        w.e = 3'b111;
        step(w, 1104, 1, outs_of(LOAD_FIRST_DATA, 0), 1, outs_of(LOAD_FIRST_DATA, 0));
        step(w, 1105, 1, outs_of(LOAD_DATA, 0), 1, outs_of(LOAD_DATA, 0));

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
